friscv_uc: RTL and testbench

//   Control unit for the FRISCV dispenser datapath. Sequences periodic distance

---
 rtl/friscv_uc_if.sv | 23 ++
 rtl/friscv_uc.sv | 119 +++++++++++
 tb/tb_friscv_uc.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/friscv_uc_if.sv
// Handshake and status bundle between the FRISCV control unit and its surroundings.
// The master side drives commands and sensor results; the slave side is the control unit.
interface friscv_uc_if;
  logic       iniciar;
  logic       cancelar;
  logic       copo_posicionado;
  logic       fim_medida;
  logic       inicia_medida;
  logic       bomba;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;

  modport master (
    output iniciar, cancelar, copo_posicionado, fim_medida,
    input  inicia_medida, bomba, pronto, erro, db_estado
  );

  modport slave (
    input  iniciar, cancelar, copo_posicionado, fim_medida,
    output inicia_medida, bomba, pronto, erro, db_estado
  );
endinterface

// File: rtl/friscv_uc.sv
// FRISCV dispenser control unit: paces distance measurements, confirms the cup with
// consecutive positive readings and runs the pump for a fixed total fill time.
module friscv_uc #(
  parameter int T_INTERVALO = 5_000_000,
  parameter int T_ENCHE     = 250_000_000,
  parameter int T_TIMEOUT   = 2_500_000,
  parameter int N_CONFIRMA  = 3
) (
  input logic        clock,
  input logic        reset,
  friscv_uc_if.slave bus
);

  localparam int INT_W  = $clog2(T_INTERVALO + 1);
  localparam int FILL_W = $clog2(T_ENCHE + 1);
  localparam int TMO_W  = $clog2(T_TIMEOUT + 1);
  localparam int CONF_W = $clog2(N_CONFIRMA + 1);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    MEDE      = 4'd1,
    AGUARDA   = 4'd2,
    AVALIA    = 4'd3,
    INTERVALO = 4'd4,
    FIM       = 4'd5,
    ERRO      = 4'd6
  } state_t;

  state_t              state, next_state;
  logic [INT_W-1:0]    int_cnt;
  logic [FILL_W-1:0]   fill_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [CONF_W-1:0]   conf_cnt;
  logic [CONF_W-1:0]   conf_inc;
  logic                enche;
  logic                pumping;
  logic                fill_done;
  logic                tmo_done;
  logic                int_done;

  assign pumping   = enche && (state inside {MEDE, AGUARDA, AVALIA, INTERVALO});
  assign fill_done = pumping && (fill_cnt == FILL_W'(T_ENCHE - 1));
  assign tmo_done  = (state == AGUARDA) && (tmo_cnt == TMO_W'(T_TIMEOUT - 1));
  assign int_done  = (state == INTERVALO) && (int_cnt == INT_W'(T_INTERVALO - 1));
  assign conf_inc  = (conf_cnt == CONF_W'(N_CONFIRMA)) ? conf_cnt : conf_cnt + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= INICIAL;
    else        state <= next_state;
  end

  // NOTE: next_state gets its default before any branch, so no path infers a latch.
  always_comb begin
    next_state = state;
    if (bus.cancelar) begin
      next_state = INICIAL;
    end else if (fill_done) begin
      next_state = FIM;
    end else begin
      unique case (state)
        INICIAL:   if (bus.iniciar) next_state = MEDE;
        MEDE:      next_state = AGUARDA;
        AGUARDA: begin
          if (tmo_done)            next_state = ERRO;
          else if (bus.fim_medida) next_state = AVALIA;
        end
        AVALIA:    next_state = INTERVALO;
        INTERVALO: if (int_done) next_state = MEDE;
        FIM, ERRO: if (bus.iniciar) next_state = MEDE;
        default:   next_state = INICIAL;
      endcase
    end
  end

  // Timers restart from zero every time their state is entered; each exits before
  // reaching its parameter value, so none can wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      int_cnt <= '0;
    end else begin
      tmo_cnt <= (state == AGUARDA)   ? tmo_cnt + 1'b1 : '0;
      int_cnt <= (state == INTERVALO) ? int_cnt + 1'b1 : '0;
    end
  end

  // Fill progress survives cup removal; only idle, done and error states reset it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_cnt <= '0;
      conf_cnt <= '0;
      enche    <= 1'b0;
    end else if (state inside {INICIAL, FIM, ERRO}) begin
      fill_cnt <= '0;
      conf_cnt <= '0;
      enche    <= 1'b0;
    end else begin
      if (pumping) fill_cnt <= fill_cnt + 1'b1;
      if (state == AVALIA) begin
        if (bus.copo_posicionado) begin
          conf_cnt <= conf_inc;
          if (conf_inc == CONF_W'(N_CONFIRMA)) enche <= 1'b1;
        end else begin
          conf_cnt <= '0;
          enche    <= 1'b0;
        end
      end
    end
  end

  assign bus.inicia_medida = (state == MEDE);
  assign bus.bomba         = pumping;
  assign bus.pronto        = (state == FIM);
  assign bus.erro          = (state == ERRO);
  assign bus.db_estado     = state;

endmodule

// File: tb/tb_friscv_uc.sv
// Directed bench for friscv_uc with a small distance-sensor model that answers each
// measurement request after a programmable delay.
module tb_friscv_uc;

  logic clock;
  logic reset;

  friscv_uc_if bus ();

  friscv_uc #(
    .T_INTERVALO(10),
    .T_ENCHE    (50),
    .T_TIMEOUT  (20),
    .N_CONFIRMA (3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  int cyc;
  int bomba_cnt;
  int first_rise;
  int last_rise;
  int first_fall;
  int aguarda_cnt;
  int done_cyc;
  bit bomba_q;

  int fim_delay;
  int bad_read;
  int drop_from;
  int read_idx;
  int cnt;
  bit pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: advance, let outputs settle, then run the sensor model and
  // update the pump statistics for the cycle just entered.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    bus.fim_medida = 1'b0;
    if (bus.inicia_medida) begin
      read_idx++;
      cnt  = fim_delay;
      pend = 1'b1;
    end else if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend = 1'b0;
        if (drop_from == 0 || read_idx < drop_from) begin
          bus.fim_medida       = 1'b1;
          bus.copo_posicionado = (read_idx == bad_read) ? 1'b0 : 1'b1;
        end
      end
    end
    if (bus.bomba) begin
      bomba_cnt++;
      if (!bomba_q) begin
        if (first_rise < 0) first_rise = cyc;
        last_rise = cyc;
      end
    end else if (bomba_q && first_fall < 0) begin
      first_fall = cyc;
    end
    bomba_q = bus.bomba;
    if (bus.db_estado == 4'd2) aguarda_cnt++;
  endtask

  // Pulses iniciar; cycle 0 is the first MEDE cycle.
  task automatic start_run(input int d, input int bad, input int drop);
    fim_delay   = d;
    bad_read    = bad;
    drop_from   = drop;
    read_idx    = 0;
    cnt         = 0;
    pend        = 1'b0;
    bomba_cnt   = 0;
    first_rise  = -1;
    last_rise   = -1;
    first_fall  = -1;
    aguarda_cnt = 0;
    bomba_q     = 1'b0;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done(input int budget);
    while (!(bus.pronto || bus.erro) && cyc < budget) tick();
    done_cyc = cyc;
  endtask

  initial begin
    reset                = 1'b0;
    bus.iniciar          = 1'b0;
    bus.cancelar         = 1'b0;
    bus.copo_posicionado = 1'b0;
    bus.fim_medida       = 1'b0;
    cyc                  = 0;
    #2;
    check("rst_estado", bus.db_estado, 0);
    check("rst_outputs", {bus.inicia_medida, bus.bomba, bus.pronto, bus.erro}, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Idle: no iniciar keeps INICIAL, and a stray fim_medida is ignored.
    tick();
    bus.fim_medida = 1'b1;
    @(posedge clock);
    #1 bus.fim_medida = 1'b0;
    check("idle_estado", bus.db_estado, 0);

    // Normal fill; the 50th pump cycle coincides with fim_medida.
    start_run(5, 0, 0);
    check("norm_mede", bus.db_estado, 1);
    check("norm_req", bus.inicia_medida, 1);
    wait_done(300);
    check("norm_rise", first_rise, 41);
    check("norm_fall", first_fall, 91);
    check("norm_done_cyc", done_cyc, 91);
    check("norm_pump_total", bomba_cnt, 50);
    check("norm_pronto", bus.pronto, 1);
    check("norm_erro", bus.erro, 0);
    check("norm_estado", bus.db_estado, 5);
    check("norm_bomba_off", bus.bomba, 0);
    repeat (3) tick();
    check("norm_pronto_held", {bus.pronto, bus.db_estado}, {1'b1, 4'd5});

    // Cup removed at the 5th reading, then reconfirmed by readings 6-8.
    start_run(5, 5, 0);
    check("rem_restart", {bus.pronto, bus.db_estado}, {1'b0, 4'd1});
    wait_done(400);
    check("rem_fall", first_fall, 75);
    check("rem_resume", last_rise, 126);
    check("rem_pump_total", bomba_cnt, 50);
    check("rem_done_cyc", done_cyc, 142);
    check("rem_estado", bus.db_estado, 5);

    // Sensor never answers.
    start_run(5, 0, 1);
    wait_done(100);
    check("tmo_done_cyc", done_cyc, 21);
    check("tmo_aguarda_cycles", aguarda_cnt, 20);
    check("tmo_erro", bus.erro, 1);
    check("tmo_estado", bus.db_estado, 6);
    check("tmo_bomba", {bus.bomba, bus.pronto}, 0);
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    check("tmo_restart", {bus.erro, bus.db_estado, bus.inicia_medida}, {1'b0, 4'd1, 1'b1});
    bus.cancelar = 1'b1;
    tick();
    bus.cancelar = 1'b0;
    check("tmo_cancel", bus.db_estado, 0);

    // Cancel while pumping.
    start_run(5, 0, 0);
    while (!bus.bomba && cyc < 100) tick();
    check("can_pump_on", cyc, 41);
    bus.cancelar = 1'b1;
    tick();
    bus.cancelar = 1'b0;
    check("can_bomba", bus.bomba, 0);
    check("can_estado", bus.db_estado, 0);
    check("can_req", bus.inicia_medida, 0);
    repeat (2) tick();
    check("can_stays_idle", {bus.db_estado, bus.inicia_medida}, 0);

    // Fill completes in the same cycle the 5th measurement times out.
    start_run(7, 0, 5);
    wait_done(300);
    check("col_rise", first_rise, 47);
    check("col_done_cyc", done_cyc, 97);
    check("col_pronto_erro", {bus.pronto, bus.erro}, 2'b10);
    check("col_estado", bus.db_estado, 5);
    check("col_pump_total", bomba_cnt, 50);

    // Asynchronous reset while pumping, checked before any clock edge.
    start_run(5, 0, 0);
    repeat (50) tick();
    check("ar_pre_bomba", bus.bomba, 1);
    #3 reset = 1'b0;
    #1;
    check("ar_estado", bus.db_estado, 0);
    check("ar_outputs", {bus.inicia_medida, bus.bomba, bus.pronto, bus.erro}, 0);
    @(posedge clock);
    #1 reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
